// File: rtl/mem_if_pkg.sv
// Shared types and widths for the cache/main-memory line port arbiter.
package mem_if_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    IC = 1'b0,
    DC = 1'b1
  } req_id_t;

  // The requester that did not receive the given grant.
  function automatic req_id_t other_id(input req_id_t id);
    return (id == IC) ? DC : IC;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant between icache and dcache: round-robin or dcache-first on ties.
module rr_arbiter2
  import mem_if_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic    ic_rqst,
  input  logic    dc_rqst,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant_id
);

  // Pick a winner; a tie goes to whoever was not granted last, or to DC.
  always_comb begin
    grant_valid = ic_rqst | dc_rqst;
    grant_id    = IC;
    if (ic_rqst && dc_rqst) begin
      grant_id = RR_EN ? other_id(last_grant) : DC;
    end else if (dc_rqst) begin
      grant_id = DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory line port between icache refills and dcache
// refills/write-backs, one transaction at a time, routing each response
// back to its owner.
module mem_arbiter #(
  parameter int unsigned ADDR_W = mem_if_pkg::ADDR_W,
  parameter int unsigned LINE_W = mem_if_pkg::LINE_W,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ic_rqst_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              ic_cancel_i,
  output logic              ic_data_ready_o,
  output logic [LINE_W-1:0] ic_data_o,
  output logic [ADDR_W-1:0] ic_addr_o,
  input  logic              dc_rqst_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_data_ready_o,
  output logic [LINE_W-1:0] dc_data_o,
  output logic [ADDR_W-1:0] dc_addr_o,
  output logic              mem_rqst_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_data_ready_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              busy_o
);
  import mem_if_pkg::*;

  state_t  state_q, state_d;
  req_id_t owner_q, last_grant_q;
  logic    drop_q;
  logic    grant_valid;
  req_id_t grant_id;
  logic    grant;
  logic    complete;
  logic    cancel_hit;
  logic    deliver_ic;
  logic    deliver_dc;

  rr_arbiter2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .ic_rqst    (ic_rqst_i),
    .dc_rqst    (dc_rqst_i),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // Transaction events; a cancel coinciding with completion also drops the line.
  always_comb begin
    grant      = (state_q == IDLE) && grant_valid;
    complete   = (state_q == WAIT) && mem_data_ready_i;
    cancel_hit = ic_cancel_i && (owner_q == IC) &&
                 ((state_q == ISSUE) || (state_q == WAIT));
    deliver_ic = complete && (owner_q == IC) && !drop_q && !ic_cancel_i;
    deliver_dc = complete && (owner_q == DC);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant, one issue cycle, wait for memory, one settle cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_data_ready_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    mem_rqst_o = (state_q == ISSUE);
    busy_o     = (state_q == ISSUE) || (state_q == WAIT);
  end

  // Latch the winner's transaction onto the memory port at grant time.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      owner_q      <= IC;
      last_grant_q <= DC;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else if (grant) begin
      owner_q      <= grant_id;
      last_grant_q <= grant_id;
      if (grant_id == DC) begin
        mem_we_o    <= dc_we_i;
        mem_addr_o  <= dc_addr_i;
        mem_wdata_o <= dc_wdata_i;
      end else begin
        mem_we_o    <= 1'b0;
        mem_addr_o  <= ic_addr_i;
        mem_wdata_o <= '0;
      end
    end
  end

  // Remember an icache cancel until its transaction completes.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      drop_q <= 1'b0;
    end else if (complete) begin
      drop_q <= 1'b0;
    end else if (cancel_hit) begin
      drop_q <= 1'b1;
    end
  end

  // Icache response: one-cycle pulse, line and address held until the next one.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      ic_data_ready_o <= 1'b0;
      ic_data_o       <= '0;
      ic_addr_o       <= '0;
    end else begin
      ic_data_ready_o <= deliver_ic;
      if (deliver_ic) begin
        ic_data_o <= mem_data_i;
        ic_addr_o <= mem_addr_o;
      end
    end
  end

  // Dcache response: refill data or write acknowledge, same timing as icache.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      dc_data_ready_o <= 1'b0;
      dc_data_o       <= '0;
      dc_addr_o       <= '0;
    end else begin
      dc_data_ready_o <= deliver_dc;
      if (deliver_dc) begin
        dc_data_o <= mem_data_i;
        dc_addr_o <= mem_addr_o;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle,
// directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;
  import mem_if_pkg::*;

  logic         clk_i = 1'b0;
  logic         rsn_i = 1'b0;
  logic         ic_rqst_i = 1'b0;
  logic [19:0]  ic_addr_i = '0;
  logic         ic_cancel_i = 1'b0;
  logic         ic_data_ready_o;
  logic [127:0] ic_data_o;
  logic [19:0]  ic_addr_o;
  logic         dc_rqst_i = 1'b0;
  logic         dc_we_i = 1'b0;
  logic [19:0]  dc_addr_i = '0;
  logic [127:0] dc_wdata_i = '0;
  logic         dc_data_ready_o;
  logic [127:0] dc_data_o;
  logic [19:0]  dc_addr_o;
  logic         mem_rqst_o;
  logic         mem_we_o;
  logic [19:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_data_ready_i = 1'b0;
  logic [127:0] mem_data_i = '0;
  logic         busy_o;

  // fixed-priority instance sharing the same inputs
  logic         f_ic_rdy, f_dc_rdy, f_mem_rqst, f_mem_we, f_busy;
  logic [127:0] f_ic_data, f_dc_data, f_mem_wdata;
  logic [19:0]  f_ic_addr, f_dc_addr, f_mem_addr;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(20), .LINE_W(128), .RR_EN(1'b1)) u_dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_rqst_i(ic_rqst_i), .ic_addr_i(ic_addr_i), .ic_cancel_i(ic_cancel_i),
    .ic_data_ready_o(ic_data_ready_o), .ic_data_o(ic_data_o), .ic_addr_o(ic_addr_o),
    .dc_rqst_i(dc_rqst_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_data_ready_o(dc_data_ready_o), .dc_data_o(dc_data_o), .dc_addr_o(dc_addr_o),
    .mem_rqst_o(mem_rqst_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_data_ready_i(mem_data_ready_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o)
  );

  mem_arbiter #(.ADDR_W(20), .LINE_W(128), .RR_EN(1'b0)) u_dut_fp (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_rqst_i(ic_rqst_i), .ic_addr_i(ic_addr_i), .ic_cancel_i(ic_cancel_i),
    .ic_data_ready_o(f_ic_rdy), .ic_data_o(f_ic_data), .ic_addr_o(f_ic_addr),
    .dc_rqst_i(dc_rqst_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_data_ready_o(f_dc_rdy), .dc_data_o(f_dc_data), .dc_addr_o(f_dc_addr),
    .mem_rqst_o(f_mem_rqst), .mem_we_o(f_mem_we), .mem_addr_o(f_mem_addr),
    .mem_wdata_o(f_mem_wdata), .mem_data_ready_i(mem_data_ready_i), .mem_data_i(mem_data_i),
    .busy_o(f_busy)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [127:0] line_of(input logic [19:0] a);
    return {4{12'h000, a}};
  endfunction

  // ---------------- transaction-level model (RR_EN = 1) ----------------
  // A transaction is: granted on a free edge, issued the next cycle, then
  // waits for memory; the edge that sees completion starts one cooldown cycle.
  logic         m_inflight = 1'b0;
  int unsigned  m_age = 0;
  logic         m_cool = 1'b0;
  logic         m_drop = 1'b0;
  req_id_t      m_owner = IC;
  req_id_t      m_last = DC;
  logic         m_rdy_edge = 1'b0;
  logic         e_we = 1'b0;
  logic [19:0]  e_addr = '0;
  logic [127:0] e_wdata = '0;
  logic         e_ic_rdy = 1'b0, e_dc_rdy = 1'b0;
  logic [127:0] e_ic_data = '0, e_dc_data = '0;
  logic [19:0]  e_ic_addr = '0, e_dc_addr = '0;
  req_id_t      m_log[$];

  always @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      m_inflight = 1'b0; m_age = 0; m_cool = 1'b0; m_drop = 1'b0;
      m_owner = IC; m_last = DC; m_rdy_edge = 1'b0;
      e_we = 1'b0; e_addr = '0; e_wdata = '0;
      e_ic_rdy = 1'b0; e_dc_rdy = 1'b0;
      e_ic_data = '0; e_dc_data = '0; e_ic_addr = '0; e_dc_addr = '0;
    end else begin
      m_rdy_edge = mem_data_ready_i;
      e_ic_rdy = 1'b0;
      e_dc_rdy = 1'b0;
      if (m_cool) begin
        m_cool = 1'b0;
      end else if (m_inflight) begin
        if (m_owner == IC && ic_cancel_i) m_drop = 1'b1;
        if (m_age > 0 && mem_data_ready_i) begin
          if (m_owner == DC) begin
            e_dc_rdy = 1'b1; e_dc_data = mem_data_i; e_dc_addr = e_addr;
          end else if (!m_drop) begin
            e_ic_rdy = 1'b1; e_ic_data = mem_data_i; e_ic_addr = e_addr;
          end
          m_inflight = 1'b0; m_cool = 1'b1; m_drop = 1'b0;
        end else begin
          m_age++;
        end
      end else if (ic_rqst_i || dc_rqst_i) begin
        if (ic_rqst_i && dc_rqst_i) m_owner = (m_last == IC) ? DC : IC;
        else m_owner = dc_rqst_i ? DC : IC;
        m_last = m_owner;
        m_log.push_back(m_owner);
        m_inflight = 1'b1; m_age = 0;
        e_addr  = (m_owner == DC) ? dc_addr_i : ic_addr_i;
        e_we    = (m_owner == DC) ? dc_we_i : 1'b0;
        e_wdata = dc_wdata_i;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=no_event required=event", nm);
  endtask

  logic cmp_en = 1'b0;

  task automatic compare_outputs();
    chk("busy", busy_o, m_inflight);
    chk("mem_rqst", mem_rqst_o, m_inflight && (m_age == 0));
    chk("mem_we", mem_we_o, e_we);
    chk("mem_addr", mem_addr_o, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("ic_rdy", ic_data_ready_o, e_ic_rdy);
    chk("ic_data", ic_data_o, e_ic_data);
    chk("ic_addr", ic_addr_o, e_ic_addr);
    chk("dc_rdy", dc_data_ready_o, e_dc_rdy);
    chk("dc_data", dc_data_o, e_dc_data);
    chk("dc_addr", dc_addr_o, e_dc_addr);
    if (ic_data_ready_o || dc_data_ready_o) chk("resp_latency", m_rdy_edge, 1'b1);
  endtask

  // ---------------- stimulus helpers ----------------
  int unsigned cyc = 0;
  int unsigned last_rdy_cyc = 0;
  int unsigned ic_pulses = 0, dc_pulses = 0;
  logic        mem_auto = 1'b1;
  int unsigned mem_lat = 5;
  int unsigned mem_cnt = 0;
  logic        auto_drop = 1'b1;
  logic [19:0] q_rr[$];
  logic [19:0] q_fp[$];

  // One cycle: compare, act as the two caches and the memory.
  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if (cmp_en) compare_outputs();
    if (ic_data_ready_o) ic_pulses++;
    if (dc_data_ready_o) dc_pulses++;
    if (auto_drop && ic_data_ready_o) ic_rqst_i = 1'b0;
    if (auto_drop && dc_data_ready_o) begin dc_rqst_i = 1'b0; dc_we_i = 1'b0; end
    if (mem_rqst_o) q_rr.push_back(mem_addr_o);
    if (f_mem_rqst) q_fp.push_back(f_mem_addr);
    if (mem_auto) begin
      mem_data_ready_i = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_data_ready_i = 1'b1;
          mem_data_i = line_of(mem_addr_o);
          last_rdy_cyc = cyc;
        end
      end
      if (mem_rqst_o) mem_cnt = mem_lat;
    end
  endtask

  task automatic wait_issue(input int unsigned budget, input string nm);
    for (int unsigned n = 0; n < budget; n++) begin
      tick();
      if (mem_rqst_o) return;
    end
    fail_timeout(nm);
  endtask

  task automatic run_quiet(input int unsigned budget, input string nm);
    int unsigned n = 0;
    while (busy_o || ic_rqst_i || dc_rqst_i || mem_cnt != 0) begin
      if (n == budget) begin
        fail_timeout(nm);
        return;
      end
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    tick();
    #2 rsn_i = 1'b0;
    mem_cnt = 0;
    tick();
    tick();
    #2 rsn_i = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int unsigned ic0, dc0, mb, qb, fb;
    logic [19:0] rr_exp[4];
    req_id_t     m_exp[4];
    rr_exp = '{20'h01000, 20'h02000, 20'h01000, 20'h02000};
    m_exp  = '{IC, DC, IC, DC};

    // reset
    tick();
    cmp_en = 1'b1;
    tick();
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_mem_rqst", mem_rqst_o, 1'b0);
    chk("reset_mem_addr", mem_addr_o, 20'h0);
    chk("reset_ic_data", ic_data_o, 128'h0);
    chk("reset_dc_rdy", dc_data_ready_o, 1'b0);
    tick();
    #2 rsn_i = 1'b1;

    // 1: single icache refill, memory latency 5
    mem_lat = 5;
    ic_addr_i = 20'h00440;
    ic_rqst_i = 1'b1;
    ic0 = ic_pulses; dc0 = dc_pulses;
    wait_issue(10, "t1_issue");
    chk("t1_mem_addr", mem_addr_o, 20'h00440);
    chk("t1_mem_we", mem_we_o, 1'b0);
    run_quiet(40, "t1_quiet");
    chk("t1_ic_pulses", ic_pulses - ic0, 1);
    chk("t1_dc_pulses", dc_pulses - dc0, 0);
    chk("t1_ic_data", ic_data_o, 128'h00000440_00000440_00000440_00000440);
    chk("t1_ic_addr", ic_addr_o, 20'h00440);

    // 2: both requesting continuously from reset
    do_reset();
    mem_lat = 1;
    auto_drop = 1'b0;
    mb = m_log.size(); qb = q_rr.size(); fb = q_fp.size();
    ic_addr_i = 20'h01000;
    dc_addr_i = 20'h02000;
    dc_we_i = 1'b0;
    ic_rqst_i = 1'b1;
    dc_rqst_i = 1'b1;
    for (int unsigned n = 0; n < 40 && q_rr.size() < qb + 4; n++) tick();
    ic_rqst_i = 1'b0;
    dc_rqst_i = 1'b0;
    auto_drop = 1'b1;
    run_quiet(40, "t2_quiet");
    for (int i = 0; i < 4; i++) begin
      chk("t2_rr_grant", q_rr[qb + i], rr_exp[i]);
      chk("t2_fp_grant", q_fp[fb + i], 20'h02000);
      chk("t2_model_grant", 128'(m_log[mb + i]), 128'(m_exp[i]));
    end

    // 3: dcache write-back
    mem_lat = 4;
    dc_addr_i = 20'h1F000;
    dc_we_i = 1'b1;
    dc_wdata_i = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    dc_rqst_i = 1'b1;
    dc0 = dc_pulses;
    wait_issue(10, "t3_issue");
    chk("t3_mem_we", mem_we_o, 1'b1);
    chk("t3_mem_addr", mem_addr_o, 20'h1F000);
    chk("t3_mem_wdata", mem_wdata_o, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    tick();
    tick();
    chk("t3_wdata_held", mem_wdata_o, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    run_quiet(40, "t3_quiet");
    chk("t3_dc_pulses", dc_pulses - dc0, 1);
    chk("t3_dc_addr", dc_addr_o, 20'h1F000);

    // 4: icache cancel 2 cycles into WAIT, dcache waiting behind it
    mem_lat = 6;
    ic_addr_i = 20'h00800;
    ic_rqst_i = 1'b1;
    ic0 = ic_pulses;
    wait_issue(10, "t4_ic_issue");
    dc_addr_i = 20'h03000;
    dc_we_i = 1'b0;
    dc_rqst_i = 1'b1;
    tick();
    tick();
    ic_cancel_i = 1'b1;
    ic_rqst_i = 1'b0;
    tick();
    ic_cancel_i = 1'b0;
    wait_issue(20, "t4_dc_issue");
    chk("t4_dc_grant_addr", mem_addr_o, 20'h03000);
    chk("t4_grant_spacing", cyc - last_rdy_cyc, 3);
    run_quiet(40, "t4_quiet");
    chk("t4_ic_pulses", ic_pulses - ic0, 0);

    // 5: cancel coinciding with completion, then spurious completion in IDLE
    mem_auto = 1'b0;
    ic_addr_i = 20'h00C00;
    ic_rqst_i = 1'b1;
    ic0 = ic_pulses; dc0 = dc_pulses;
    wait_issue(10, "t5_issue");
    tick();
    tick();
    mem_data_ready_i = 1'b1;
    mem_data_i = {4{32'h5A5A5A5A}};
    ic_cancel_i = 1'b1;
    ic_rqst_i = 1'b0;
    tick();
    mem_data_ready_i = 1'b0;
    ic_cancel_i = 1'b0;
    tick();
    tick();
    chk("t5_busy", busy_o, 1'b0);
    qb = q_rr.size();
    mem_data_ready_i = 1'b1;
    tick();
    mem_data_ready_i = 1'b0;
    tick();
    tick();
    chk("t5_spurious_busy", busy_o, 1'b0);
    chk("t5_spurious_issue", q_rr.size() - qb, 0);
    chk("t5_ic_pulses", ic_pulses - ic0, 0);
    chk("t5_dc_pulses", dc_pulses - dc0, 0);
    chk("t5_ic_data_held", ic_data_o, 128'h00001000_00001000_00001000_00001000);

    // 6: reset during WAIT, stale completion afterwards, then a tie
    ic_addr_i = 20'h00440;
    ic_rqst_i = 1'b1;
    ic0 = ic_pulses; dc0 = dc_pulses;
    wait_issue(10, "t6_issue");
    tick();
    #2 rsn_i = 1'b0;
    ic_rqst_i = 1'b0;
    tick();
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_mem_addr", mem_addr_o, 20'h0);
    chk("t6_rst_ic_data", ic_data_o, 128'h0);
    chk("t6_rst_dc_addr", dc_addr_o, 20'h0);
    #2 rsn_i = 1'b1;
    tick();
    mem_data_ready_i = 1'b1;
    mem_data_i = {4{32'h0BAD0BAD}};
    tick();
    mem_data_ready_i = 1'b0;
    tick();
    tick();
    chk("t6_stale_busy", busy_o, 1'b0);
    chk("t6_stale_pulses", (ic_pulses - ic0) + (dc_pulses - dc0), 0);
    mem_auto = 1'b1;
    mem_lat = 2;
    dc_addr_i = 20'h05000;
    dc_we_i = 1'b0;
    ic_rqst_i = 1'b1;
    dc_rqst_i = 1'b1;
    wait_issue(10, "t6_tie_issue");
    chk("t6_tie_winner", mem_addr_o, 20'h00440);
    run_quiet(60, "t6_quiet");
    chk("t6_ic_addr", ic_addr_o, 20'h00440);
    chk("t6_dc_addr", dc_addr_o, 20'h05000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
